// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - state encoding and datapath select constants for the multicycle controller
//
// Purpose: shared types and constants for multicycle_ctrl and the datapath it steers.
//   state_t      : FSM state codes (FETCH=0 .. UNKNOWN=10; codes 11-15 are unused)
//   SRCA_*       : ALU A operand select values
//   SRCB_*       : ALU B operand select values
//   RES_*        : result bus select values
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_RN       = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;

  localparam logic [1:0] SRCB_RM       = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing a multicycle ARM-subset datapath
//
// Purpose: steps each instruction through fetch, decode, and the memory /
// execute / branch paths, driving datapath selects and unconditioned enables.
// Optional build macro: MCTRL_MEMRDY_EN - when defined, a low iMemReady stalls
// FETCH, MEMREAD and MEMWRITE; otherwise iMemReady is ignored.
//
// Ports:
//   iClk, iReset_n           clock, asynchronous active-low reset
//   iOp[1:0], iFunct[5:0]    instruction fields (sampled in DECODE / MEMADR only)
//   iMemReady                memory access complete this cycle
//   oIRWrite, oNextPC        load IR, write PC+4
//   oAdrSrc                  memory address select (0=PC, 1=ALUOut)
//   oALUSrcA, oALUSrcB       ALU operand selects
//   oResultSrc               result bus select
//   oRegW, oMemW, oBranch    unconditioned write / branch enables
//   oALUOp                   enable ALU-control decode downstream
//   oIllegal                 one-cycle pulse on an unimplemented op
//   oState[3:0]              current state code (debug)
module multicycle_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic [1:0] iOp,
  input  logic [5:0] iFunct,
  input  logic       iMemReady,
  output logic       oIRWrite,
  output logic       oNextPC,
  output logic       oAdrSrc,
  output logic [1:0] oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oResultSrc,
  output logic       oRegW,
  output logic       oMemW,
  output logic       oBranch,
  output logic       oALUOp,
  output logic       oIllegal,
  output logic [3:0] oState
);

  state_t state, state_nx;
  logic   mem_ok;
  logic   unused_ok;

`ifdef MCTRL_MEMRDY_EN
  assign mem_ok    = iMemReady;
  assign unused_ok = ^iFunct[4:1];
`else
  assign mem_ok    = 1'b1;
  assign unused_ok = ^{iFunct[4:1], iMemReady};
`endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= S_FETCH;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:    state_nx = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (iOp)
          2'b00:   state_nx = iFunct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nx = S_MEMADR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_nx = iFunct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nx = mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = mem_ok ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_UNKNOWN:  state_nx = S_FETCH;
      default:    state_nx = S_FETCH;
    endcase
  end

  logic irw_d, npc_d, regw_d, memw_d, ill_d;

  always_comb begin
    irw_d      = 1'b0;
    npc_d      = 1'b0;
    regw_d     = 1'b0;
    memw_d     = 1'b0;
    ill_d      = 1'b0;
    oAdrSrc    = 1'b0;
    oALUSrcA   = SRCA_RN;
    oALUSrcB   = SRCB_RM;
    oResultSrc = RES_ALUOUT;
    oBranch    = 1'b0;
    oALUOp     = 1'b0;
    case (state)
      S_FETCH: begin
        // IR/PC update only once the instruction word has actually arrived.
        irw_d      = mem_ok;
        npc_d      = mem_ok;
        oALUSrcA   = SRCA_PC;
        oALUSrcB   = SRCB_FOUR;
        oResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        oALUSrcA   = SRCA_PC;
        oALUSrcB   = SRCB_FOUR;
        oResultSrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        oALUSrcA = SRCA_RN;
        oALUSrcB = SRCB_EXTIMM;
      end
      S_MEMREAD: begin
        oAdrSrc    = 1'b1;
        oResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        oResultSrc = RES_DATA;
        regw_d     = 1'b1;
      end
      S_MEMWRITE: begin
        oAdrSrc = 1'b1;
        memw_d  = 1'b1;
      end
      S_EXECR: begin
        oALUSrcB = SRCB_RM;
        oALUOp   = 1'b1;
      end
      S_EXECI: begin
        oALUSrcB = SRCB_EXTIMM;
        oALUOp   = 1'b1;
      end
      S_ALUWB: begin
        oResultSrc = RES_ALUOUT;
        regw_d     = 1'b1;
      end
      S_BRANCH: begin
        oALUSrcB   = SRCB_EXTIMM;
        oResultSrc = RES_ALURESULT;
        oBranch    = 1'b1;
      end
      S_UNKNOWN: ill_d = 1'b1;
      default: ;
    endcase
  end

  // The register already snaps to FETCH on reset, but FETCH itself asserts
  // IR/PC writes; hold every write enable low while reset is applied.
  assign oIRWrite = irw_d  & iReset_n;
  assign oNextPC  = npc_d  & iReset_n;
  assign oRegW    = regw_d & iReset_n;
  assign oMemW    = memw_d & iReset_n;
  assign oIllegal = ill_d  & iReset_n;
  assign oState   = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; the encoding is fixed.
REQ-002 iClk  input  1  single clock; all state changes on the rising edge.
REQ-003 iReset_n  input  1  asynchronous, active-low reset.
REQ-004 iOp  input  2  instruction op field from the instruction register.
REQ-005 iFunct  input  6  instruction funct field; [5]=I, [0]=S/L.
REQ-006 iMemReady  input  1  memory access complete this cycle.
REQ-007 oIRWrite  output  1  load the instruction register.
REQ-008 oNextPC  output  1  write PC+4 to the PC.
REQ-009 oAdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 oALUSrcA  output  2  ALU A select: 00=Rn, 01=PC.
REQ-011 oALUSrcB  output  2  ALU B select: 00=Rm, 01=ExtImm, 10=const 4.
REQ-012 oResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 oRegW, oMemW, oBranch, oALUOp  output  1 each  unconditioned write, branch and ALU-decode enables; condition gating happens downstream.
REQ-014 oIllegal  output  1  one-cycle pulse on an unimplemented op.
REQ-015 oState  output  4  current state encoding, for debug.

Function
REQ-016 The block SHALL be a Moore FSM; every output SHALL be decoded only from the state register, except for the iMemReady gating in REQ-027.
REQ-017 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10; codes 11-15 SHALL go to FETCH.
REQ-018 Transitions SHALL be:
- FETCH->DECODE.
- DECODE decodes on iOp: iOp=00 goes to EXECI if iFunct[5]=1, otherwise EXECR; iOp=01 goes to MEMADR; iOp=10 goes to BRANCH; iOp=11 goes to UNKNOWN.
- MEMADR->MEMREAD if iFunct[0]=1, otherwise MEMWRITE.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECR and EXECI->ALUWB->FETCH.
- BRANCH->FETCH; UNKNOWN->FETCH.
REQ-019 FETCH outputs: oIRWrite=1, oNextPC=1, oAdrSrc=0, oALUSrcA=01, oALUSrcB=10, oResultSrc=10.
REQ-020 DECODE outputs: oALUSrcA=01, oALUSrcB=10, oResultSrc=10.
REQ-021 MEMADR outputs: oALUSrcA=00, oALUSrcB=01.
- MEMREAD: oAdrSrc=1, oResultSrc=00.
- MEMWB: oResultSrc=01, oRegW=1.
- MEMWRITE: oAdrSrc=1, oMemW=1.
REQ-022 Execute and branch outputs:
- EXECR: oALUSrcB=00, oALUOp=1.
- EXECI: oALUSrcB=01, oALUOp=1.
- ALUWB: oResultSrc=00, oRegW=1.
- BRANCH: oALUSrcB=01, oResultSrc=10, oBranch=1.
- UNKNOWN: oIllegal=1.
REQ-023 Any output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-024 Latencies without stalls SHALL be: LDR 5 cycles; STR 4 cycles; data-processing 4 cycles; B 3 cycles; unimplemented op 3 cycles.
REQ-025 iOp and iFunct SHALL be sampled only in DECODE and MEMADR, and SHALL be ignored in every other state.

Reset
REQ-026 While iReset_n=0, the state SHALL be FETCH and oIRWrite, oNextPC, oRegW, oMemW and oIllegal SHALL be forced to 0; on deassertion, FETCH outputs are driven starting that cycle.
- A reset asserted mid-instruction SHALL abandon the instruction with no further write enable asserted.

Configuration
REQ-027 With MCTRL_MEMRDY_EN defined, a low iMemReady SHALL stall FETCH, MEMREAD and MEMWRITE.
- While stalled, the FSM SHALL hold its state.
- In FETCH, oIRWrite and oNextPC SHALL be gated by iMemReady.
- In MEMWRITE, oMemW SHALL stay asserted until the cycle iMemReady=1.
REQ-028 Without MCTRL_MEMRDY_EN, iMemReady SHALL remain a port but SHALL be ignored; memory is single-cycle.

Structure
REQ-029 Package arm_ctrl_pkg SHALL hold:
- the state enum;
- the oALUSrcA, oALUSrcB and oResultSrc select constants.
REQ-030 No sub-module is required; ALU-control and flag decode remain in the existing decoder, driven by oALUOp.

Verification
REQ-031 Reset with iReset_n=0 for 3 cycles, then release -> oState=0 with oIRWrite=0 during reset; oIRWrite=1 on the first cycle after release.
REQ-032 ADD register (iOp=00, iFunct=001000) -> states 0,1,6,8,0; oALUOp=1 in EXECR; oRegW=1 only in ALUWB.
REQ-033 LDR (iOp=01, iFunct=011001) -> states 0,1,2,3,4,0; oAdrSrc=1 in MEMREAD; oResultSrc=01 and oRegW=1 in MEMWB.
REQ-034 STR (iOp=01, iFunct=011000), with MCTRL_MEMRDY_EN and iMemReady=0 for 2 cycles in MEMWRITE -> MEMWRITE held 3 cycles, oMemW=1 throughout, then FETCH.
REQ-035 B (iOp=10), then iOp=11 -> states 0,1,9,0 with oBranch=1 for exactly one cycle; then states 0,1,10,0 with oIllegal=1 for exactly one cycle.
REQ-036 Reset asserted in MEMWB -> oRegW drops to 0 immediately (asynchronously); FETCH is entered after release.
